avmm_fetch_data_arbiter: RTL and testbench

AVMM_FETCH_DATA_ARBITER -- requirements
Module: avmm_fetch_data_arbiter

---
 rtl/avmm_arb_pkg.sv | 20 ++
 rtl/arb_rr_picker.sv | 24 ++
 rtl/avmm_fetch_data_arbiter.sv | 153 +++++++++++++++
 tb/tb_avmm_fetch_data_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avmm_arb_pkg.sv
// Shared state encoding and requester ids for the fetch/data Avalon-MM arbiter.
// Build macro ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise the data side has priority.
package avmm_arb_pkg;

    typedef logic req_id_t;

    localparam req_id_t REQ_IF = 1'b0;
    localparam req_id_t REQ_DS = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit ARB_RR_EN = 1'b1;
`else
    localparam bit ARB_RR_EN = 1'b0;
`endif

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational two-way grant between instruction fetch and data side.
// With ARB_ROUND_ROBIN_EN defined, a tie goes to the side not granted last; otherwise data wins ties.
module arb_rr_picker
    import avmm_arb_pkg::*;
(
    input  logic    if_req_i,
    input  logic    ds_req_i,
    input  req_id_t last_grant_i,
    output logic    valid_o,
    output req_id_t grant_o
);

    always_comb begin
        valid_o = if_req_i | ds_req_i;
        if (if_req_i && ds_req_i) begin
            grant_o = (ARB_RR_EN && (last_grant_i == REQ_DS)) ? REQ_IF : REQ_DS;
        end else if (if_req_i) begin
            grant_o = REQ_IF;
        end else begin
            grant_o = REQ_DS;
        end
    end

endmodule

// File: rtl/avmm_fetch_data_arbiter.sv
// Shares one Avalon-MM master between an instruction-fetch port and a data port.
// Tie-break policy is set by ARB_ROUND_ROBIN_EN (see arb_rr_picker); every Avalon output is registered.
module avmm_fetch_data_arbiter
    import avmm_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,

    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    output logic                  if_ready_o,

    input  logic                  ds_req_i,
    input  logic                  ds_we_i,
    input  logic [ADDR_W-1:0]     ds_addr_i,
    input  logic [DATA_W-1:0]     ds_wdata_i,
    input  logic [DATA_W/8-1:0]   ds_be_i,
    output logic                  ds_ready_o,

    output logic [DATA_W-1:0]     rdata_o,

    output logic [ADDR_W-1:0]     m_address_o,
    output logic                  m_read_o,
    output logic                  m_write_o,
    output logic [DATA_W-1:0]     m_writedata_o,
    output logic [DATA_W/8-1:0]   m_byteenable_o,
    input  logic                  m_waitrequest_i,
    input  logic [DATA_W-1:0]     m_readdata_i
);

    logic [1:0]            state_q, state_d;
    req_id_t               owner_q, owner_d;
    req_id_t               last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  read_q, read_d;
    logic                  write_q, write_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   be_q, be_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  if_ready_q, if_ready_d;
    logic                  ds_ready_q, ds_ready_d;

    logic                  pick_valid;
    req_id_t               pick_id;

    arb_rr_picker u_picker (
        .if_req_i     (if_req_i),
        .ds_req_i     (ds_req_i),
        .last_grant_i (last_grant_q),
        .valid_o      (pick_valid),
        .grant_o      (pick_id)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        read_d       = read_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        rdata_d      = rdata_q;
        if_ready_d   = 1'b0;
        ds_ready_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Requests are only looked at here; changes during BUS/DONE wait for the next IDLE.
                if (pick_valid) begin
                    owner_d      = pick_id;
                    last_grant_d = pick_id;
                    state_d      = ST_BUS;
                    if (pick_id == REQ_DS) begin
                        addr_d  = ds_addr_i;
                        wdata_d = ds_wdata_i;
                        be_d    = ds_be_i;
                        write_d = ds_we_i;
                        read_d  = ~ds_we_i;
                    end else begin
                        addr_d  = if_addr_i;
                        wdata_d = '0;
                        be_d    = '1;
                        write_d = 1'b0;
                        read_d  = 1'b1;
                    end
                end
            end
            ST_BUS: begin
                if (!m_waitrequest_i) begin
                    if (read_q) begin
                        rdata_d = m_readdata_i;
                    end
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = ST_DONE;
                    if (owner_q == REQ_DS) begin
                        ds_ready_d = 1'b1;
                    end else begin
                        if_ready_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= REQ_IF;
            last_grant_q <= REQ_DS;
            addr_q       <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            be_q         <= '0;
            rdata_q      <= '0;
            if_ready_q   <= 1'b0;
            ds_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            read_q       <= read_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            rdata_q      <= rdata_d;
            if_ready_q   <= if_ready_d;
            ds_ready_q   <= ds_ready_d;
        end
    end

    assign m_address_o    = addr_q;
    assign m_read_o       = read_q;
    assign m_write_o      = write_q;
    assign m_writedata_o  = wdata_q;
    assign m_byteenable_o = be_q;
    assign rdata_o        = rdata_q;
    assign if_ready_o     = if_ready_q;
    assign ds_ready_o     = ds_ready_q;

endmodule

// File: tb/tb_avmm_fetch_data_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_avmm_fetch_data_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ready;
    logic          ds_req = 1'b0;
    logic          ds_we = 1'b0;
    logic [AW-1:0] ds_addr = '0;
    logic [DW-1:0] ds_wdata = '0;
    logic [BW-1:0] ds_be = '0;
    logic          ds_ready;
    logic [DW-1:0] rdata;
    logic [AW-1:0] m_address;
    logic          m_read;
    logic          m_write;
    logic [DW-1:0] m_writedata;
    logic [BW-1:0] m_byteenable;
    logic          m_waitrequest = 1'b0;
    logic [DW-1:0] m_readdata = '0;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    avmm_fetch_data_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .if_req_i       (if_req),
        .if_addr_i      (if_addr),
        .if_ready_o     (if_ready),
        .ds_req_i       (ds_req),
        .ds_we_i        (ds_we),
        .ds_addr_i      (ds_addr),
        .ds_wdata_i     (ds_wdata),
        .ds_be_i        (ds_be),
        .ds_ready_o     (ds_ready),
        .rdata_o        (rdata),
        .m_address_o    (m_address),
        .m_read_o       (m_read),
        .m_write_o      (m_write),
        .m_writedata_o  (m_writedata),
        .m_byteenable_o (m_byteenable),
        .m_waitrequest_i(m_waitrequest),
        .m_readdata_i   (m_readdata)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: one transaction owns the bus from its grant until waitrequest
    // is sampled low; the requester's ready follows one cycle later and the next grant is
    // considered two cycles after completion.
    int            cyc = 0;
    int            arb_from = 0;
    bit            on_bus = 1'b0;
    bit            cur_ds = 1'b0;
    bit            last_ds = 1'b1;
    bit            pick_ds;
    logic          e_read = 1'b0, e_write = 1'b0, e_ifr = 1'b0, e_dsr = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wd = '0, e_rdata = '0;
    logic [BW-1:0] e_be = '0;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            cyc = 0; arb_from = 0; on_bus = 1'b0; last_ds = 1'b1;
            e_read = 1'b0; e_write = 1'b0; e_ifr = 1'b0; e_dsr = 1'b0;
            e_addr = '0; e_wd = '0; e_rdata = '0; e_be = '0;
        end else begin
            e_ifr = 1'b0;
            e_dsr = 1'b0;
            if (on_bus) begin
                if (!m_waitrequest) begin
                    if (e_read) e_rdata = m_readdata;
                    e_read = 1'b0;
                    e_write = 1'b0;
                    on_bus = 1'b0;
                    if (cur_ds) e_dsr = 1'b1; else e_ifr = 1'b1;
                    arb_from = cyc + 2;
                end
            end else if (cyc >= arb_from && (if_req || ds_req)) begin
                if (if_req && ds_req) pick_ds = RR ? !last_ds : 1'b1;
                else pick_ds = ds_req;
                cur_ds = pick_ds;
                last_ds = pick_ds;
                on_bus = 1'b1;
                if (pick_ds) begin
                    e_addr = ds_addr; e_wd = ds_wdata; e_be = ds_be;
                    e_write = ds_we; e_read = !ds_we;
                end else begin
                    e_addr = if_addr; e_be = '1;
                    e_write = 1'b0; e_read = 1'b1;
                end
            end
            cyc++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("m_read", 64'(m_read), 64'(e_read));
            chk("m_write", 64'(m_write), 64'(e_write));
            chk("if_ready", 64'(if_ready), 64'(e_ifr));
            chk("ds_ready", 64'(ds_ready), 64'(e_dsr));
            chk("rdata", 64'(rdata), 64'(e_rdata));
            if (e_read || e_write) begin
                chk("m_address", 64'(m_address), 64'(e_addr));
                chk("m_byteenable", 64'(m_byteenable), 64'(e_be));
            end
            if (e_write) chk("m_writedata", 64'(m_writedata), 64'(e_wd));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(output bit ifr, output bit dsr);
        @(negedge clk);
        ifr = if_ready;
        dsr = ds_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic new_if();
        if_req = 1'b1;
        if_addr = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic new_ds();
        ds_req = 1'b1;
        ds_we = 1'($urandom_range(0, 1));
        ds_addr = $urandom & 32'hFFFF_FFFC;
        ds_wdata = $urandom;
        ds_be = 4'($urandom_range(0, 15));
    endtask

    initial begin
        bit ifr, dsr, stop, got_rdy;
        int ng, wcnt, rdy_cnt, last_w, rdy_at, nr, ny;
        int iss_if, iss_ds, done_if, done_ds;
        bit got[4];
        bit exp_g[4];
        int rd_at[2];
        int rdy_e[2];

        #1 reset = 1'b1;
        #1 cmp_en = 1'b1;
        @(negedge clk);
        chk("reset_m_read", 64'(m_read), 64'd0);
        chk("reset_m_address", 64'(m_address), 64'd0);
        chk("reset_rdata", 64'(rdata), 64'd0);
        chk("reset_readies", 64'({if_ready, ds_ready}), 64'd0);
        tick();

        // Single fetch at minimum latency.
        reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h100; m_waitrequest = 1'b0; m_readdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("A_c0_m_read", 64'(m_read), 64'd0);
        tick();
        @(negedge clk);
        chk("A_c1_m_read", 64'(m_read), 64'd1);
        chk("A_c1_m_address", 64'(m_address), 64'h100);
        chk("A_c1_m_be", 64'(m_byteenable), 64'hF);
        tick();
        @(negedge clk);
        chk("A_c2_if_ready", 64'(if_ready), 64'd1);
        chk("A_c2_rdata", 64'(rdata), 64'hDEADBEEF);
        chk("A_c2_m_read", 64'(m_read), 64'd0);
        chk("A_model_ifr", 64'(e_ifr), 64'd1);
        chk("A_model_rdata", 64'(e_rdata), 64'hDEADBEEF);
        tick();
        if_req = 1'b0;

        // Both requesters held: grant order.
        if_req = 1'b1; if_addr = 32'h104;
        ds_req = 1'b1; ds_we = 1'b0; ds_addr = 32'h300; ds_be = 4'hF;
        ng = 0; stop = 1'b0;
        exp_g[0] = 1'b1; exp_g[1] = !RR; exp_g[2] = 1'b1; exp_g[3] = !RR;
        for (int i = 0; i < 80 && (if_req || ds_req); i++) begin
            cycle(ifr, dsr);
            if ((ifr || dsr) && ng < 4) begin
                got[ng] = dsr;
                ng++;
            end
            if (ng >= 4) stop = 1'b1;
            if (ifr && stop) if_req = 1'b0;
            if (dsr && stop) ds_req = 1'b0;
        end
        chk("C_timeout", 64'({if_req, ds_req}), 64'd0);
        chk("C_grants", 64'(ng), 64'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("C_grant%0d_is_ds", i), 64'(got[i]), 64'(exp_g[i]));

        // Stalled write: rdata must keep the last read value.
        ds_req = 1'b1; ds_we = 1'b1; ds_addr = 32'h200; ds_wdata = 32'h12345678; ds_be = 4'h3;
        m_waitrequest = 1'b1; m_readdata = 32'hBAD0BAD0;
        wcnt = 0; rdy_cnt = 0; last_w = -1; rdy_at = -1;
        for (int c = 0; c < 30 && ds_req; c++) begin
            @(negedge clk);
            if (m_write) begin
                wcnt++;
                last_w = c;
                if (wcnt == 1) begin
                    chk("B_m_address", 64'(m_address), 64'h200);
                    chk("B_m_writedata", 64'(m_writedata), 64'h12345678);
                    chk("B_m_be", 64'(m_byteenable), 64'h3);
                end
            end
            if (ds_ready) begin
                rdy_cnt++;
                rdy_at = c;
            end
            m_waitrequest = (wcnt < 4);
            tick();
            if (rdy_at == c) ds_req = 1'b0;
        end
        chk("B_timeout", 64'(ds_req), 64'd0);
        chk("B_write_cycles", 64'(wcnt), 64'd4);
        chk("B_ready_count", 64'(rdy_cnt), 64'd1);
        chk("B_ready_delay", 64'(rdy_at - last_w), 64'd1);
        @(negedge clk);
        chk("B_rdata_kept", 64'(rdata), 64'hDEADBEEF);
        tick();

        // Reset in the middle of a stalled fetch.
        if_req = 1'b1; if_addr = 32'h140; m_waitrequest = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("D_stalled_m_read", 64'(m_read), 64'd1);
        #2 reset = 1'b1;
        if_req = 1'b0;
        #1;
        chk("D_async_m_read", 64'(m_read), 64'd0);
        chk("D_async_m_address", 64'(m_address), 64'd0);
        chk("D_async_rdata", 64'(rdata), 64'd0);
        chk("D_async_be", 64'(m_byteenable), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("D_no_ready", 64'({if_ready, ds_ready}), 64'd0);
        end
        tick();
        reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h180; m_waitrequest = 1'b0; m_readdata = 32'hCAFEF00D;
        tick();
        @(negedge clk);
        chk("D_new_m_read", 64'(m_read), 64'd1);
        chk("D_new_m_address", 64'(m_address), 64'h180);
        tick();
        @(negedge clk);
        chk("D_new_if_ready", 64'(if_ready), 64'd1);
        chk("D_new_rdata", 64'(rdata), 64'hCAFEF00D);
        tick();
        if_req = 1'b0;

        // Back-to-back fetches: cadence.
        if_req = 1'b1; if_addr = 32'h0; m_waitrequest = 1'b0;
        nr = 0; ny = 0;
        rd_at[0] = -100; rd_at[1] = -100; rdy_e[0] = -100; rdy_e[1] = -100;
        for (int c = 0; c < 20 && if_req; c++) begin
            @(negedge clk);
            if (m_read && nr < 2 && (nr == 0 || c > rd_at[0] + 1)) begin
                rd_at[nr] = c;
                nr++;
                if (nr == 2) chk("E_second_addr", 64'(m_address), 64'h4);
            end
            got_rdy = if_ready;
            if (if_ready && ny < 2) begin
                rdy_e[ny] = c;
                ny++;
            end
            tick();
            if (got_rdy) begin
                if (ny == 1) if_addr = 32'h4; else if_req = 1'b0;
            end
        end
        chk("E_reads", 64'(nr), 64'd2);
        chk("E_readies", 64'(ny), 64'd2);
        chk("E_first_latency", 64'(rdy_e[0] - rd_at[0]), 64'd1);
        chk("E_ready_to_read", 64'(rd_at[1] - rdy_e[0]), 64'd2);
        chk("E_cadence", 64'(rd_at[1] - rd_at[0]), 64'd3);

        // Randomized traffic against the model.
        if_req = 1'b0; ds_req = 1'b0;
        iss_if = 0; iss_ds = 0; done_if = 0; done_ds = 0;
        for (int i = 0; i < 3000; i++) begin
            cycle(ifr, dsr);
            m_waitrequest = ($urandom_range(0, 2) == 0);
            m_readdata = $urandom;
            if (ifr) begin done_if++; if_req = 1'b0; end
            if (dsr) begin done_ds++; ds_req = 1'b0; end
            if (!if_req && $urandom_range(0, 2) != 0) begin new_if(); iss_if++; end
            if (!ds_req && $urandom_range(0, 2) != 0) begin new_ds(); iss_ds++; end
        end
        m_waitrequest = 1'b0;
        for (int i = 0; i < 200 && (if_req || ds_req); i++) begin
            cycle(ifr, dsr);
            if (ifr) begin done_if++; if_req = 1'b0; end
            if (dsr) begin done_ds++; ds_req = 1'b0; end
        end
        chk("R_drain_timeout", 64'({if_req, ds_req}), 64'd0);
        chk("R_if_completed", 64'(done_if), 64'(iss_if));
        chk("R_ds_completed", 64'(done_ds), 64'(iss_ds));
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
